// File: rtl/memory_responder.sv
// memory_responder
// ----------------
// Memory-side responder for the control unit's MOV/MOC handshake. A request
// (address from MAR, write data from MDR, read/write, size) is captured when
// mov rises in IDLE, waits LATENCY cycles in BUSY, and is then performed
// against an internal big-endian byte array. Completion is signalled on moc.
// moc, err and read data are held until mov is released.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-low reset
//   mov       in   memory operation valid
//   rw        in   1 = read, 0 = write
//   size      in   00 byte, 01 halfword, 10 word, 11 reserved (error)
//   addr      in   byte address (MAR)
//   data_in   in   write data (MDR), right-justified
//   data_out  out  read data, zero-extended, 0 for writes and errors
//   moc       out  memory operation complete
//   err       out  request rejected, valid while moc = 1
//   dbg_addr  in   debug byte address
//   dbg_data  out  mem[dbg_addr], combinational
module memory_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mov,
  input  logic                     rw,
  input  logic [1:0]               size,
  input  logic [31:0]              addr,
  input  logic [31:0]              data_in,
  output logic [31:0]              data_out,
  output logic                     moc,
  output logic                     err,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr,
  output logic [7:0]               dbg_data
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [3:0]  LAT_C   = 4'(LATENCY);
  localparam logic [32:0] DEPTH_C = 33'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic        moc_q, moc_d;
  logic        err_q, err_d;
  logic [31:0] dout_q, dout_d;

  logic [7:0]  mem_q [DEPTH];

  logic [32:0]   last_off_s;
  logic [32:0]   end_addr_s;
  logic          size_bad_s;
  logic          align_bad_s;
  logic          range_bad_s;
  logic          req_err_s;
  logic [AW-1:0] a0_s, a1_s, a2_s, a3_s;
  logic [31:0]   rdata_s;
  logic          access_s;
  logic          we_s;

  // Decode the captured size into last-byte offset, alignment and reserved checks.
  always_comb begin
    last_off_s  = 33'd0;
    size_bad_s  = 1'b0;
    align_bad_s = 1'b0;
    case (size_q)
      2'b00: begin
        last_off_s = 33'd0;
      end
      2'b01: begin
        last_off_s  = 33'd1;
        align_bad_s = addr_q[0];
      end
      2'b10: begin
        last_off_s  = 33'd3;
        align_bad_s = |addr_q[1:0];
      end
      default: begin
        size_bad_s = 1'b1;
      end
    endcase
  end

  // Range check on the full 32-bit address, widened so addr+3 cannot wrap.
  assign end_addr_s  = {1'b0, addr_q} + last_off_s;
  assign range_bad_s = (end_addr_s >= DEPTH_C);
  assign req_err_s   = size_bad_s | align_bad_s | range_bad_s;

  assign a0_s = addr_q[AW-1:0];
  assign a1_s = a0_s + AW'(1);
  assign a2_s = a0_s + AW'(2);
  assign a3_s = a0_s + AW'(3);

  // Big-endian read assembly, zero-extended to 32 bits.
  always_comb begin
    rdata_s = 32'd0;
    case (size_q)
      2'b00:   rdata_s = {24'd0, mem_q[a0_s]};
      2'b01:   rdata_s = {16'd0, mem_q[a0_s], mem_q[a1_s]};
      2'b10:   rdata_s = {mem_q[a0_s], mem_q[a1_s], mem_q[a2_s], mem_q[a3_s]};
      default: rdata_s = 32'd0;
    endcase
  end

  // The access happens on the BUSY edge where the wait has expired and mov is still held.
  assign access_s = (state_q == ST_BUSY) && mov && (cnt_q == 4'd0);
  assign we_s     = access_s && !rw_q && !req_err_s;

  // Handshake state machine next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    moc_d   = moc_q;
    err_d   = err_q;
    dout_d  = dout_q;
    case (state_q)
      ST_IDLE: begin
        if (mov) begin
          addr_d  = addr;
          rw_d    = rw;
          size_d  = size;
          wdata_d = data_in;
          cnt_d   = LAT_C;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!mov) begin
          // Abort: nothing has been written yet, moc never rose.
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_DONE;
          moc_d   = 1'b1;
          err_d   = req_err_s;
          dout_d  = (req_err_s || !rw_q) ? 32'd0 : rdata_s;
        end
      end
      ST_DONE: begin
        if (!mov) begin
          state_d = ST_IDLE;
          moc_d   = 1'b0;
          err_d   = 1'b0;
          dout_d  = 32'd0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        moc_d   = 1'b0;
        err_d   = 1'b0;
        dout_d  = 32'd0;
      end
    endcase
  end

  // State and request registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      rw_q    <= 1'b0;
      size_q  <= 2'b00;
      wdata_q <= 32'd0;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      moc_q   <= moc_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  // Byte-array write port; contents survive reset, but reset blocks a pending write.
  always_ff @(posedge clk) begin
    if (reset && we_s) begin
      case (size_q)
        2'b00: begin
          mem_q[a0_s] <= wdata_q[7:0];
        end
        2'b01: begin
          mem_q[a0_s] <= wdata_q[15:8];
          mem_q[a1_s] <= wdata_q[7:0];
        end
        2'b10: begin
          mem_q[a0_s] <= wdata_q[31:24];
          mem_q[a1_s] <= wdata_q[23:16];
          mem_q[a2_s] <= wdata_q[15:8];
          mem_q[a3_s] <= wdata_q[7:0];
        end
        default: begin
        end
      endcase
    end
  end

  assign data_out = dout_q;
  assign moc      = moc_q;
  assign err      = err_q;
  assign dbg_data = mem_q[dbg_addr];

endmodule
